sram_arbiter: RTL and testbench

//  Shares the single 256Kx16 off-chip SRAM between two 32-bit requesters.

---
 rtl/sram_arb_pkg.sv | 20 ++
 rtl/sram_arb_pick.sv | 31 +++
 rtl/sram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and widths for the SRAM arbiter
//
// Purpose : FSM state enum, SRAM bus widths and phase counter width used by
//           sram_arbiter and sram_arb_pick.
// Ports   : none (package)
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int SRAM_AW  = 18;           // half-word address width
  localparam int SRAM_DW  = 16;           // data bus width
  localparam int WORD_AW  = SRAM_AW - 1;  // 32-bit word index width
  localparam int PHASE_CW = 8;            // phase counter width, holds WAIT_CYCLES-1

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - combinational winner select for the SRAM arbiter
//
// Purpose : Chooses which requester is granted when the arbiter is idle.
//           Default build: fixed priority, port0 always wins.
//           With SRAM_ARB_RR_EN defined: on a collision the port that was not
//           served last wins.
// Ports   : i_req0, i_req1 - request lines of port0 / port1
//           i_last         - port served by the previous access (1 = port1)
//           o_any          - at least one request pending
//           o_gnt          - winning port (0 = port0, 1 = port1)
module sram_arb_pick (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_any,
  output logic o_gnt
);

  assign o_any = i_req0 | i_req1;

`ifdef SRAM_ARB_RR_EN
  // Collision: grant the port that did not win last time.
  assign o_gnt = (i_req0 & i_req1) ? ~i_last : i_req1;
`else
  // Last-granted history is irrelevant under fixed priority.
  logic w_unused_last;
  assign w_unused_last = i_last;
  assign o_gnt = i_req1 & ~i_req0;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port 32-bit arbiter onto a 256Kx16 async SRAM
//
// Purpose : Arbitrates port0 (CPU MEM stage) and port1 (debug/DMA loader),
//           then splits the winner's 32-bit access into a low and a high
//           16-bit SRAM phase of WAIT_CYCLES cycles each.
//           Optional macro SRAM_ARB_RR_EN selects round-robin arbitration
//           (see sram_arb_pick); undefined means fixed port0 priority.
// Ports   : clk                 - rising-edge clock
//           rst                 - asynchronous active-low reset
//           reqN/weN            - request / write(1) read(0) of port N
//           addrN/wdataN        - byte address / write data of port N
//           rdataN              - last read data returned to port N
//           readyN              - port N not stalled (combinational)
//           SRAM_DQ             - bidirectional SRAM data bus
//           SRAM_ADDR           - SRAM half-word address
//           SRAM_WE_N/SRAM_OE_N - active-low write / output enables
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BASE   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               we0,
  input  logic [31:0]        addr0,
  input  logic [31:0]        wdata0,
  output logic [31:0]        rdata0,
  output logic               ready0,
  input  logic               req1,
  input  logic               we1,
  input  logic [31:0]        addr1,
  input  logic [31:0]        wdata1,
  output logic [31:0]        rdata1,
  output logic               ready1,
  inout  logic [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N
);

  localparam logic [PHASE_CW-1:0] LAST_CNT = PHASE_CW'(WAIT_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PHASE_CW-1:0]  r_cnt;
  logic                 r_gnt;
  logic                 r_we;
  logic [WORD_AW-1:0]   r_word;
  logic [31:0]          r_wdata;
  logic [SRAM_DW-1:0]   r_rd_lo;
  logic [31:0]          r_rdata0;
  logic [31:0]          r_rdata1;
  logic                 r_last;

  logic                 w_any;
  logic                 w_pick;
  logic                 w_cnt_last;
  logic [31:0]          w_sel_addr;
  logic [31:0]          w_off;
  logic [14:0]          w_unused_off;
  logic                 w_dq_oe;
  logic [SRAM_DW-1:0]   w_dq_out;

  sram_arb_pick u_pick (
    .i_req0 (req0),
    .i_req1 (req1),
    .i_last (r_last),
    .o_any  (w_any),
    .o_gnt  (w_pick)
  );

  assign w_cnt_last = (r_cnt == LAST_CNT);
  assign w_sel_addr = w_pick ? addr1 : addr0;
  // Word index relative to the base; bits above the 2^17-word window wrap away.
  assign w_off        = w_sel_addr - 32'(ADDR_BASE);
  assign w_unused_off = {w_off[31:19], w_off[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    SRAM_ADDR   = '0;
    SRAM_WE_N   = 1'b1;
    SRAM_OE_N   = 1'b1;
    w_dq_oe     = 1'b0;
    w_dq_out    = '0;
    case (r_state)
      IDLE: begin
        if (w_any) w_state_nxt = LO;
      end
      LO, HI: begin
        if (w_cnt_last) w_state_nxt = (r_state == LO) ? HI : DONE;
        SRAM_ADDR = {r_word, (r_state == HI)};
        if (r_we) begin
          w_dq_oe   = 1'b1;
          w_dq_out  = (r_state == HI) ? r_wdata[31:16] : r_wdata[15:0];
          // WE_N rises on the last count while data is still driven,
          // giving the SRAM its data hold time.
          SRAM_WE_N = w_cnt_last;
        end else begin
          SRAM_OE_N = 1'b0;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign SRAM_DQ = w_dq_oe ? w_dq_out : {SRAM_DW{1'bz}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_gnt    <= 1'b0;
      r_we     <= 1'b0;
      r_word   <= '0;
      r_wdata  <= '0;
      r_rd_lo  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_last   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_any) begin
            r_gnt   <= w_pick;
            r_we    <= w_pick ? we1 : we0;
            r_word  <= w_off[18:2];
            r_wdata <= w_pick ? wdata1 : wdata0;
          end
        end
        LO: begin
          r_cnt <= w_cnt_last ? '0 : r_cnt + PHASE_CW'(1);
          // Low half is staged so rdataN only changes when the whole word is in.
          if (!r_we && w_cnt_last) r_rd_lo <= SRAM_DQ;
        end
        HI: begin
          r_cnt <= w_cnt_last ? '0 : r_cnt + PHASE_CW'(1);
          if (!r_we && w_cnt_last) begin
            if (r_gnt) r_rdata1 <= {SRAM_DQ, r_rd_lo};
            else       r_rdata0 <= {SRAM_DQ, r_rd_lo};
          end
        end
        DONE: begin
          r_last <= r_gnt;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;
  assign ready0 = ~req0 | ((r_state == DONE) & ~r_gnt);
  assign ready1 = ~req1 | ((r_state == DONE) &  r_gnt);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
`timescale 1ns/1ps
module tb_sram_arbiter;

  localparam int W    = 2;
  localparam int BASE = 1024;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1, rdata0, rdata1;
  logic        ready0, ready1;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N, SRAM_OE_N;

  always #5 clk = ~clk;

  sram_arbiter #(.WAIT_CYCLES(W), .ADDR_BASE(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .rdata0    (rdata0),
    .ready0    (ready0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .rdata1    (rdata1),
    .ready1    (ready1),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_OE_N (SRAM_OE_N)
  );

  // SRAM device model: drives on OE_N low, captures mid-cycle while WE_N low.
  logic [15:0] mem [0:262143];
  int          we_lows = 0;
  assign SRAM_DQ = (!SRAM_OE_N) ? mem[SRAM_ADDR] : 16'hzzzz;
  always @(negedge clk) begin
    if (!SRAM_WE_N) begin
      mem[SRAM_ADDR] <= SRAM_DQ;
      we_lows <= we_lows + 1;
    end
  end

  // Reference model: 32-bit word store, per-port read results, last-served port.
  logic [31:0] gmem [int];
  logic [31:0] m_rd [2];
  int          m_last;
  int          n_assert = 0;
  int          n_fail   = 0;

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(BASE);
    return int'((off / 32'd4) % 32'd131072);
  endfunction

  function automatic logic [31:0] model_rd(input int w);
    return gmem.exists(w) ? gmem[w] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input int w);
    chk(tag, {mem[2*w+1], mem[2*w]}, model_rd(w));
  endtask

  // One arbitration round: the enabled ports raise req together at cycle 0
  // and drop it on the cycle their ready is seen.
  task automatic run_txn(input bit e0, input bit wr0, input logic [31:0] a0, input logic [31:0] d0,
                         input bit e1, input bit wr1, input logic [31:0] a1, input logic [31:0] d1);
    bit          en [2];
    bit          wr [2];
    int          ww [2];
    logic [31:0] dd [2];
    int          exp_cyc [2];
    int          got [2];
    int          first, p, nwr, lows0, idle_bad;
    en[0] = e0; en[1] = e1; wr[0] = wr0; wr[1] = wr1;
    dd[0] = d0; dd[1] = d1; ww[0] = word_of(a0); ww[1] = word_of(a1);
    if (e0 && e1) first = (RR && m_last == 0) ? 1 : 0;
    else          first = e0 ? 0 : 1;
    exp_cyc[first]     = 2*W + 1;
    exp_cyc[1 - first] = 2*(2*W + 1) + 1;
    nwr = 0;
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? first : 1 - first;
      if (en[p]) begin
        if (wr[p]) begin gmem[ww[p]] = dd[p]; nwr++; end
        else m_rd[p] = model_rd(ww[p]);
        m_last = p;
      end
    end
    @(negedge clk);
    req0 = e0; we0 = wr0; addr0 = a0; wdata0 = d0;
    req1 = e1; we1 = wr1; addr1 = a1; wdata1 = d1;
    got[0] = -1; got[1] = -1; lows0 = we_lows; idle_bad = 0;
    for (int c = 1; c <= 30 && ((e0 && got[0] < 0) || (e1 && got[1] < 0)); c++) begin
      @(negedge clk);
      if (!e0 && ready0 !== 1'b1) idle_bad++;
      if (!e1 && ready1 !== 1'b1) idle_bad++;
      if (e0 && got[0] < 0 && ready0) begin got[0] = c; chk("rdata0", rdata0, m_rd[0]); req0 = 1'b0; end
      if (e1 && got[1] < 0 && ready1) begin got[1] = c; chk("rdata1", rdata1, m_rd[1]); req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    if (e0) chk("ready0_cycle", got[0], exp_cyc[0]);
    if (e1) chk("ready1_cycle", got[1], exp_cyc[1]);
    chk("idle_port_ready", idle_bad, 0);
    chk("we_low_cycles", we_lows - lows0, nwr * 2 * (W - 1));
    for (int q = 0; q < 2; q++) if (en[q] && wr[q]) chk_word("sram_word", ww[q]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          cyc [3];
    int          pulses;
    logic [31:0] ra [3];
    logic [31:0] er [3];
    logic [31:0] hi_old;
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0;
    rst = 1'b0; req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    m_rd[0] = 0; m_rd[1] = 0; m_last = 1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_we_n", SRAM_WE_N, 1'b1);
    chk("rst_oe_n", SRAM_OE_N, 1'b1);
    chk("rst_addr", SRAM_ADDR, 18'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_ready0", ready0, 1'b1);
    chk("rst_ready1", ready1, 1'b1);
    rst = 1'b1;

    // Port0 write then read back at the base address
    run_txn(1, 1, 32'd1024, 32'hDEADBEEF, 0, 0, 0, 0);
    chk("t1_lo_half", mem[0], 16'hBEEF);
    chk("t1_hi_half", mem[1], 16'hDEAD);
    run_txn(1, 0, 32'd1024, 32'h0, 0, 0, 0, 0);

    // Collisions: two writes, then two more
    run_txn(1, 1, 32'd1040, 32'hA0A0A0A0, 1, 1, 32'd1044, 32'hB1B1B1B1);
    run_txn(1, 1, 32'd1048, 32'hC2C2C2C2, 1, 1, 32'd1052, 32'hD3D3D3D3);

    // Port1 write with req dropped mid-access; addr/wdata disturbed too
    @(negedge clk);
    req1 = 1; we1 = 1; addr1 = 32'd1028; wdata1 = 32'h12345678;
    repeat (2) @(negedge clk);
    req1 = 0; addr1 = 32'hFFFF_FFFC; wdata1 = 32'h0;
    repeat (4) @(negedge clk);
    gmem[word_of(32'd1028)] = 32'h12345678;
    m_last = 1;
    chk("t4_lo_half", mem[2], 16'h5678);
    chk("t4_hi_half", mem[3], 16'h1234);
    chk("t4_ready1", ready1, 1'b1);

    // Reset during the high phase of a write
    hi_old = model_rd(word_of(32'd1032));
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 32'd1032; wdata0 = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t5_we_n", SRAM_WE_N, 1'b1);
    chk("t5_oe_n", SRAM_OE_N, 1'b1);
    chk("t5_addr", SRAM_ADDR, 18'h0);
    chk("t5_rdata0", rdata0, 32'h0);
    req0 = 0;
    @(negedge clk);
    rst = 1'b1;
    gmem[word_of(32'd1032)] = {hi_old[31:16], 16'hF00D};
    m_rd[0] = 0; m_rd[1] = 0; m_last = 1;
    run_txn(1, 0, 32'd1032, 32'h0, 0, 0, 0, 0);

    // Back-to-back reads with req0 held across three accesses
    ra[0] = 32'd1024; ra[1] = 32'd1029; ra[2] = 32'd1034;
    for (int k = 0; k < 3; k++) er[k] = model_rd(word_of(ra[k]));
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = ra[0];
    pulses = 0; cyc[0] = -1; cyc[1] = -1; cyc[2] = -1;
    for (int c = 1; c <= 30 && pulses < 3; c++) begin
      @(negedge clk);
      if (ready0) begin
        cyc[pulses] = c;
        chk("t6_rdata0", rdata0, er[pulses]);
        pulses++;
        if (pulses == 3) req0 = 0;
        else addr0 = ra[pulses];
      end
    end
    req0 = 0;
    m_rd[0] = er[2]; m_last = 0;
    chk("t6_pulses", pulses, 3);
    chk("t6_pulse1", cyc[0], 5);
    chk("t6_pulse2", cyc[1], 11);
    chk("t6_pulse3", cyc[2], 17);

    // Randomized traffic, including below-base and wrapped addresses
    for (int i = 0; i < 30; i++) begin
      bit          e0, e1;
      logic [31:0] a [2];
      for (int q = 0; q < 2; q++) begin
        int k;
        k = int'($urandom_range(0, 8)) - 1;
        a[q] = 32'(BASE + 4*k) + 32'($urandom_range(0, 3)) + ($urandom_range(0, 3) == 0 ? 32'h80000 : 32'h0);
      end
      e0 = 1'($urandom_range(0, 1));
      e1 = 1'($urandom_range(0, 1));
      if (!e0 && !e1) e0 = 1'b1;
      run_txn(e0, 1'($urandom_range(0, 1)), a[0], $urandom,
              e1, 1'($urandom_range(0, 1)), a[1], $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
